// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: stall cascade, mul/div busy counter,
// deferred exception flush and stall/flush performance counters.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   stallreq_if/id/ex/mem  per-stage stall requests
//   md_start           multi-cycle mul/div issued in EX
//   except_occur       MEM-stage exception/eret, target except_target
//   stall_if..stall_wb Stall_t fields (stall_wb tied 0)
//   flush, flush_pc    flush all stage registers, redirect target
//   md_busy            mul/div counter running
//   stall_cycles       cycles with stall_if=1 (wraps)
//   flush_count        flush pulses issued (wraps)
module pipeline_ctrl #(
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             md_start,
    input  logic             except_occur,
    input  logic [31:0]      except_target,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             stall_wb,
    output logic             flush,
    output logic [31:0]      flush_pc,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [15:0]      flush_count
);

    typedef enum logic [1:0] {
        RUN,
        MD_WAIT,
        FLUSH_PEND
    } state_t;

    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  md_cnt, md_cnt_nx;
    logic [31:0] pend_pc, pend_pc_nx;

    // Stall cascade: a stage stalls itself and all earlier stages.
    always_comb begin
        md_busy   = (state == MD_WAIT);
        stall_mem = stallreq_mem;
        stall_ex  = stall_mem | stallreq_ex | md_busy;
        stall_id  = stall_ex | stallreq_id;
        stall_if  = stall_id | stallreq_if;
        stall_wb  = 1'b0;
    end

    always_comb begin
        state_nx   = state;
        md_cnt_nx  = md_cnt;
        pend_pc_nx = pend_pc;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        if (state == FLUSH_PEND) begin
            // Oldest exception wins: new except_occur ignored here.
            if (md_cnt != 8'd0)
                md_cnt_nx = md_cnt - 8'd1;
            if (!stallreq_mem) begin
                flush     = 1'b1;
                flush_pc  = pend_pc;
                state_nx  = RUN;
                md_cnt_nx = 8'd0;
            end
        end else if (except_occur) begin
            // Exception beats a same-cycle md_start.
            if (stallreq_mem) begin
                // In-flight memory access cannot be aborted.
                state_nx   = FLUSH_PEND;
                pend_pc_nx = except_target;
                if (md_cnt != 8'd0)
                    md_cnt_nx = md_cnt - 8'd1;
            end else begin
                flush     = 1'b1;
                flush_pc  = except_target;
                state_nx  = RUN;
                md_cnt_nx = 8'd0;
            end
        end else if (state == MD_WAIT) begin
            if (md_cnt == 8'd0)
                state_nx = RUN;
            else
                md_cnt_nx = md_cnt - 8'd1;
        end else if (md_start) begin
            state_nx  = MD_WAIT;
            md_cnt_nx = MD_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            md_cnt       <= 8'd0;
            pend_pc      <= 32'h0;
            stall_cycles <= '0;
            flush_count  <= 16'd0;
        end else begin
            state   <= state_nx;
            md_cnt  <= md_cnt_nx;
            pend_pc <= pend_pc_nx;
            if (stall_if)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush)
                flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios plus randomized
// run against a behavioural model.
module tb_pipeline_ctrl;

    localparam int MDC = 4;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stallreq_if = 1'b0;
    logic          stallreq_id = 1'b0;
    logic          stallreq_ex = 1'b0;
    logic          stallreq_mem = 1'b0;
    logic          md_start = 1'b0;
    logic          except_occur = 1'b0;
    logic [31:0]   except_target = 32'h0;
    logic          stall_if, stall_id, stall_ex, stall_mem, stall_wb;
    logic          flush;
    logic [31:0]   flush_pc;
    logic          md_busy;
    logic [CW-1:0] stall_cycles;
    logic [15:0]   flush_count;

    int vectors = 0;
    int errors  = 0;

    pipeline_ctrl #(.MD_CYCLES(MDC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .md_start(md_start), .except_occur(except_occur),
        .except_target(except_target),
        .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .stall_mem(stall_mem),
        .stall_wb(stall_wb), .flush(flush), .flush_pc(flush_pc),
        .md_busy(md_busy), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // req = {except, md_start, mem, ex, id, if}; outputs settle by return
    task automatic drive(input logic [5:0] req, input logic [31:0] tgt);
        @(negedge clk);
        {except_occur, md_start, stallreq_mem,
         stallreq_ex, stallreq_id, stallreq_if} = req;
        except_target = tgt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {except_occur, md_start, stallreq_mem,
         stallreq_ex, stallreq_id, stallreq_if} = 6'b0;
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] stalls();
        return {stall_if, stall_id, stall_ex, stall_mem, stall_wb};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (stalls() !== 5'b0 || flush !== 1'b0 || md_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: stalls=%b flush=%b busy=%b want 0",
                     stalls(), flush, md_busy);
        end
        vectors++;
        if (flush_pc !== 32'h0 || stall_cycles !== 0 || flush_count !== 0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h sc=%0d fc=%0d want 0",
                     flush_pc, stall_cycles, flush_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(6'b0, 32'h0);
        vectors++;
        if (stalls() !== 5'b0 || flush !== 1'b0 || stall_cycles !== 0) begin
            errors++;
            $display("FAIL reset_idle: stalls=%b flush=%b sc=%0d want 0",
                     stalls(), flush, stall_cycles);
        end
    endtask

    task automatic test_cascade();
        logic [CW-1:0] sc0;
        do_reset();
        sc0 = stall_cycles;
        for (int i = 0; i < 3; i++) begin
            drive(6'b000100, 32'h0);
            vectors++;
            if (stalls() !== 5'b11100) begin
                errors++;
                $display("FAIL casc_ex: stalls=%b want 11100", stalls());
            end
        end
        drive(6'b0, 32'h0);
        vectors++;
        if (stalls() !== 5'b0 || stall_cycles !== sc0 + CW'(3)) begin
            errors++;
            $display("FAIL casc_cnt3: stalls=%b sc=%0d want 0 %0d",
                     stalls(), stall_cycles, sc0 + CW'(3));
        end
        drive(6'b001000, 32'h0);
        vectors++;
        if (stalls() !== 5'b11110) begin
            errors++;
            $display("FAIL casc_mem: stalls=%b want 11110", stalls());
        end
        drive(6'b000010, 32'h0);
        vectors++;
        if (stalls() !== 5'b11000) begin
            errors++;
            $display("FAIL casc_id: stalls=%b want 11000", stalls());
        end
        drive(6'b000001, 32'h0);
        vectors++;
        if (stalls() !== 5'b10000) begin
            errors++;
            $display("FAIL casc_if: stalls=%b want 10000", stalls());
        end
        drive(6'b0, 32'h0);
        vectors++;
        if (stall_cycles !== sc0 + CW'(6)) begin
            errors++;
            $display("FAIL casc_cnt6: sc=%0d want %0d",
                     stall_cycles, sc0 + CW'(6));
        end
    endtask

    task automatic test_md();
        logic exp;
        do_reset();
        for (int i = 0; i <= 6; i++) begin
            drive((i == 0 || i == 2) ? 6'b010000 : 6'b0, 32'h0);
            exp = (i >= 1 && i <= MDC);
            vectors++;
            if (md_busy !== exp || stall_ex !== exp || stall_mem !== 1'b0) begin
                errors++;
                $display("FAIL md_cyc%0d: busy=%b ex=%b want %b",
                         i, md_busy, stall_ex, exp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(6'b010000, 32'h0);
            vectors++;
            if (md_busy !== (i != 0)) begin
                errors++;
                $display("FAIL md_b2b%0d: busy=%b want %b", i, md_busy, i != 0);
            end
        end
    endtask

    task automatic test_except_md();
        do_reset();
        drive(6'b010000, 32'h0);
        drive(6'b0, 32'h0);
        drive(6'b100000, 32'hBFC00380);
        vectors++;
        if (flush !== 1'b1 || flush_pc !== 32'hBFC00380 || md_busy !== 1'b1) begin
            errors++;
            $display("FAIL exc_md: flush=%b pc=%h busy=%b want 1 bfc00380 1",
                     flush, flush_pc, md_busy);
        end
        drive(6'b0, 32'h0);
        vectors++;
        if (flush !== 1'b0 || md_busy !== 1'b0 || flush_count !== 16'd1) begin
            errors++;
            $display("FAIL exc_md_after: flush=%b busy=%b fc=%0d want 0 0 1",
                     flush, md_busy, flush_count);
        end
        drive(6'b110000, 32'h00001234);
        drive(6'b0, 32'h0);
        vectors++;
        if (md_busy !== 1'b0 || flush_count !== 16'd2) begin
            errors++;
            $display("FAIL exc_vs_md: busy=%b fc=%0d want 0 2",
                     md_busy, flush_count);
        end
    endtask

    task automatic test_deferred();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0)
                drive(6'b101000, 32'h80000180);
            else if (i == 2)
                drive(6'b101000, 32'h80000200);
            else
                drive(6'b001000, 32'h0);
            vectors++;
            if (flush !== 1'b0 || stalls() !== 5'b11110) begin
                errors++;
                $display("FAIL defer_hold%0d: flush=%b stalls=%b want 0 11110",
                         i, flush, stalls());
            end
        end
        drive(6'b0, 32'h0);
        vectors++;
        if (flush !== 1'b1 || flush_pc !== 32'h80000180) begin
            errors++;
            $display("FAIL defer_fire: flush=%b pc=%h want 1 80000180",
                     flush, flush_pc);
        end
        drive(6'b0, 32'h0);
        vectors++;
        if (flush !== 1'b0 || flush_count !== 16'd1) begin
            errors++;
            $display("FAIL defer_once: flush=%b fc=%0d want 0 1",
                     flush, flush_count);
        end
    endtask

    task automatic test_reset_pend();
        do_reset();
        drive(6'b110000, 32'h0000BEEF);
        drive(6'b101000, 32'h80000180);
        drive(6'b001000, 32'h0);
        rst_n = 1'b0;
        stallreq_mem = 1'b0;
        #1;
        vectors++;
        if (stalls() !== 5'b0 || flush !== 1'b0 || flush_pc !== 32'h0 ||
            md_busy !== 1'b0 || stall_cycles !== 0 || flush_count !== 0) begin
            errors++;
            $display("FAIL rst_pend: st=%b fl=%b pc=%h b=%b sc=%0d fc=%0d",
                     stalls(), flush, flush_pc, md_busy,
                     stall_cycles, flush_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(6'b0, 32'h0);
            vectors++;
            if (flush !== 1'b0 || flush_count !== 0) begin
                errors++;
                $display("FAIL rst_pend_after%0d: flush=%b fc=%0d want 0 0",
                         i, flush, flush_count);
            end
        end
    endtask

    task automatic test_random();
        int            busy_left = 0;
        bit            pend = 0;
        logic [31:0]   ppc = '0;
        logic [CW-1:0] m_sc = '0;
        logic [15:0]   m_fc = '0;
        logic [5:0]    req;
        logic [31:0]   tgt;
        logic          e_mem, e_ex, e_id, e_if, e_fl;
        logic [31:0]   e_pc;
        do_reset();
        for (int c = 0; c < 700; c++) begin
            req[5] = ($urandom_range(9) == 0);
            req[4] = ($urandom_range(5) == 0);
            req[3] = ($urandom_range(3) == 0);
            req[2] = ($urandom_range(4) == 0);
            req[1] = ($urandom_range(4) == 0);
            req[0] = ($urandom_range(4) == 0);
            tgt = $urandom;
            drive(req, tgt);
            e_mem = req[3];
            e_ex  = e_mem | req[2] | (busy_left > 0);
            e_id  = e_ex | req[1];
            e_if  = e_id | req[0];
            e_fl  = pend ? !req[3] : (req[5] && !req[3]);
            e_pc  = !e_fl ? 32'h0 : (pend ? ppc : tgt);
            vectors++;
            if ({stall_if, stall_id, stall_ex, stall_mem, stall_wb,
                 flush, flush_pc, md_busy, stall_cycles, flush_count} !==
                {e_if, e_id, e_ex, e_mem, 1'b0,
                 e_fl, e_pc, busy_left > 0, m_sc, m_fc}) begin
                errors++;
                $display("FAIL rand%0d: st=%b fl=%b pc=%h b=%b sc=%0d fc=%0d want st=%b fl=%b pc=%h b=%b sc=%0d fc=%0d",
                         c, stalls(), flush, flush_pc, md_busy,
                         stall_cycles, flush_count,
                         {e_if, e_id, e_ex, e_mem, 1'b0}, e_fl, e_pc,
                         busy_left > 0, m_sc, m_fc);
            end
            if (e_if) m_sc = m_sc + 1'b1;
            if (e_fl) m_fc = m_fc + 1'b1;
            if (e_fl) begin
                pend = 0;
                busy_left = 0;
            end else if (!pend && req[5]) begin
                pend = 1;
                ppc = tgt;
                busy_left = 0;
            end else if (busy_left > 0) begin
                busy_left--;
            end else if (req[4] && !pend) begin
                busy_left = MDC;
            end
        end
    endtask

    initial begin
        test_reset();
        test_cascade();
        test_md();
        test_except_md();
        test_deferred();
        test_reset_pend();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the dual-issue pipeline. Collects per-stage stall requests, the multi-cycle mul/div occupancy and the MEM-stage exception. Drives the Stall_t fields and the flush line consumed by every inter-stage register (if_id, id_ex, ex_mem, mem_wb), plus the exception redirect PC. Owns the mul/div busy counter and the deferred-flush state, and keeps two performance counters.

Parameters:
MD_CYCLES, 32, cycles stall_ex is held after md_start (mul/div latency); legal range 1..255
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
stallreq_if  in  1  fetch stage stall request (icache miss)
stallreq_id  in  1  decode stall request (load-use hazard)
stallreq_ex  in  1  execute stall request (non-mul/div)
stallreq_mem  in  1  memory stall request (dcache/uncached access in flight)
md_start  in  1  EX issues a multi-cycle mul/div this cycle
except_occur  in  1  MEM-stage exception/eret committed this cycle
except_target  in  32  redirect PC for except_occur
stall_if  out  1  Stall_t.stall_if
stall_id  out  1  Stall_t.stall_id
stall_ex  out  1  Stall_t.stall_ex
stall_mem  out  1  Stall_t.stall_mem
stall_wb  out  1  Stall_t.stall_wb, tied 0
flush  out  1  flush all inter-stage registers and redirect fetch
flush_pc  out  32  fetch redirect target, valid only when flush=1
md_busy  out  1  mul/div counter running
stall_cycles  out  CNT_W  count of cycles with stall_if=1, wraps
flush_count  out  16  count of flush pulses, wraps

Behaviour:
- Reset (rst_n=0, async): state=RUN, md counter=0, pend_pc=0, stall_cycles=0, flush_count=0. Outputs: all stall_*=0, flush=0, flush_pc=0, md_busy=0.
- States: RUN, MD_WAIT, FLUSH_PEND.
- Stall cascade (combinational from inputs and registered state):
  - stall_mem = stallreq_mem
  - stall_ex = stall_mem | stallreq_ex | md_busy
  - stall_id = stall_ex | stallreq_id
  - stall_if = stall_id | stallreq_if
  - A stage stalls itself and every earlier stage. Later stages proceed, and the register after a stalled stage inserts a bubble.
- md_busy = (state==MD_WAIT).
- RUN + md_start (no exception): load counter=MD_CYCLES-1, go to MD_WAIT.
  - md_busy rises the cycle after md_start and stays high exactly MD_CYCLES cycles.
  - MD_CYCLES=1 still gives one busy cycle.
- MD_WAIT: counter decrements each cycle regardless of other stalls. At counter==0, return to RUN next cycle. md_start while in MD_WAIT is ignored.
- Exception with stallreq_mem=0:
  - flush=1 combinationally in the same cycle, flush_pc=except_target.
  - Any state goes to RUN and md counter clears; the flush aborts mul/div.
  - flush_count increments.
- Exception with stallreq_mem=1 (memory access cannot be aborted):
  - flush=0; latch pend_pc=except_target; go to FLUSH_PEND.
  - In FLUSH_PEND, flush=1 with flush_pc=pend_pc in the first cycle stallreq_mem=0, then go to RUN and increment flush_count.
  - Further except_occur while in FLUSH_PEND is ignored; the oldest exception wins.
  - md counter continues running while in FLUSH_PEND and clears on the flush cycle.
- Simultaneous except_occur and md_start: the exception wins, md_start is dropped, and no MD_WAIT is entered.
- flush and stall_* may both be 1 in the same cycle. Consumers give flush priority (register resets).
- stall_cycles increments on every clock edge where stall_if=1, including flush cycles. It wraps at 2^CNT_W.
- Reset asserted mid-MD_WAIT or mid-FLUSH_PEND: the pending flush is discarded and all state returns to reset values immediately.

Test Plan:
- Reset, all requests 0 -> all stall_*=0, flush=0, counters 0.
- Cascade: stallreq_ex=1 for 3 cycles -> stall_if/id/ex=1, stall_mem=0. Pulse stallreq_mem alone -> all four stalls=1. stall_cycles advances by exactly the stalled cycle count.
- MD_CYCLES=4, md_start at cycle 10 -> md_busy=1 at cycles 11..14, stall_ex=1 at cycles 11..14, back to RUN at cycle 15. md_start at cycle 12 is ignored.
- except_occur, except_target=0xBFC00380, stallreq_mem=0 during MD_WAIT -> same-cycle flush=1, flush_pc=0xBFC00380, md_busy=0 next cycle, flush_count=1.
- except_occur, except_target=0x80000180, with stallreq_mem=1 held 5 cycles, plus a second except at 0x80000200 during the hold -> flush=0 for 5 cycles, then flush=1 with flush_pc=0x80000180 for exactly one cycle.
- rst_n asserted low during FLUSH_PEND -> outputs immediately reset; after release, no flush is ever issued.
